// File: rtl/voice_flap_detector.sv
// voice_flap_detector: stereo->mono mix, windowed rectified-mean envelope, hysteresis and cooldown-gated flap pulse.
// Optional peak-hold register/ports enabled by defining VOICE_FLAP_PEAK_EN.
`timescale 1ns/1ps
module voice_flap_detector #(
    parameter int                DATA_W       = 24,
    parameter int                WIN_LOG2     = 10,
    parameter logic [DATA_W-1:0] TH_ON        = DATA_W'(262144),
    parameter logic [DATA_W-1:0] TH_OFF       = DATA_W'(131072),
    parameter int                COOLDOWN_WIN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [DATA_W-1:0] sample_left,
    input  logic [DATA_W-1:0] sample_right,
    output logic [DATA_W-1:0] envelope,
    output logic              level_valid,
    output logic              loud,
    output logic              flap
`ifdef VOICE_FLAP_PEAK_EN
    ,
    input  logic              peak_clr,
    output logic [DATA_W-1:0] peak
`endif
);
    localparam int ACC_W = DATA_W + WIN_LOG2;
    localparam int CD_W  = COOLDOWN_WIN > 0 ? $clog2(COOLDOWN_WIN + 1) : 1;

    typedef enum logic {ACCUM, EVAL} state_t;

    state_t            r_state;
    logic              r_ready;
    logic [ACC_W-1:0]  r_acc;
    logic [WIN_LOG2-1:0] r_cnt;
    logic [CD_W-1:0]   r_cd;
    logic [DATA_W-1:0] r_env;
    logic              r_lv;
    logic              r_loud;
    logic              r_flap;

    logic signed [DATA_W:0]   w_sum;
    logic signed [DATA_W-1:0] w_mono;
    logic [DATA_W-1:0]        w_mag;
    logic [DATA_W-1:0]        w_env;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_loud_n;
    logic                     w_flap_n;

    // One extra bit keeps L+R exact; the halved sum always fits back in DATA_W.
    assign w_sum    = $signed({sample_left[DATA_W-1], sample_left}) + $signed({sample_right[DATA_W-1], sample_right});
    assign w_mono   = DATA_W'(w_sum >>> 1);
    assign w_mag    = w_mono[DATA_W-1] ? DATA_W'(0) - $unsigned(w_mono) : $unsigned(w_mono);
    assign w_env    = DATA_W'(r_acc >> WIN_LOG2);
    assign w_accept = sample_valid & r_ready;
    assign w_last   = w_accept & (&r_cnt);
    assign w_loud_n = r_loud ? (w_env >= TH_OFF) : (w_env >= TH_ON);
    assign w_flap_n = !r_loud & w_loud_n & (r_cd == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ACCUM;
            r_ready <= 1'b1;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_cd    <= '0;
            r_env   <= '0;
            r_lv    <= 1'b0;
            r_loud  <= 1'b0;
            r_flap  <= 1'b0;
        end else begin
            r_lv   <= 1'b0;
            r_flap <= 1'b0;
            if (r_state == ACCUM) begin
                if (w_accept) begin
                    r_acc <= r_acc + ACC_W'(w_mag);
                    r_cnt <= r_cnt + WIN_LOG2'(1);
                end
                if (w_last) begin
                    r_state <= EVAL;
                    r_ready <= 1'b0;
                end
            end else begin
                r_env   <= w_env;
                r_lv    <= 1'b1;
                r_loud  <= w_loud_n;
                r_flap  <= w_flap_n;
                r_cd    <= w_flap_n ? CD_W'(COOLDOWN_WIN) : (r_cd != '0 ? r_cd - CD_W'(1) : r_cd);
                r_acc   <= '0;
                r_cnt   <= '0;
                r_state <= ACCUM;
                r_ready <= 1'b1;
            end
        end
    end

    assign sample_ready = r_ready;
    assign envelope     = r_env;
    assign level_valid  = r_lv;
    assign loud         = r_loud;
    assign flap         = r_flap;

`ifdef VOICE_FLAP_PEAK_EN
    logic [DATA_W-1:0] r_peak;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_peak <= '0;
        else if (peak_clr)
            r_peak <= '0;
        else if (r_state == EVAL && w_env > r_peak)
            r_peak <= w_env;
    end

    assign peak = r_peak;
`endif
endmodule

// File: tb/tb_voice_flap_detector.sv
// tb_voice_flap_detector: directed + randomized windows checked against a window-level arithmetic model.
`timescale 1ns/1ps
module tb_voice_flap_detector;
    localparam int DW  = 24;
    localparam int WL  = 2;
    localparam int N   = 4;
    localparam int ON  = 1000;
    localparam int OFF = 500;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sample_valid;
    logic          sample_ready;
    logic [DW-1:0] sample_left;
    logic [DW-1:0] sample_right;
    logic [DW-1:0] envelope;
    logic          level_valid;
    logic          loud;
    logic          flap;
`ifdef VOICE_FLAP_PEAK_EN
    logic          peak_clr;
    logic [DW-1:0] peak;
`endif

    voice_flap_detector #(
        .DATA_W(DW), .WIN_LOG2(WL), .TH_ON(24'd1000), .TH_OFF(24'd500), .COOLDOWN_WIN(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_left(sample_left), .sample_right(sample_right), .envelope(envelope),
        .level_valid(level_valid), .loud(loud), .flap(flap)
`ifdef VOICE_FLAP_PEAK_EN
        , .peak_clr(peak_clr), .peak(peak)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int wl[N];
    int wr[N];
    bit m_loud;
    int m_cd;
    int m_peak;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Mean over the window of |floor((L+R)/2)|, using plain integer arithmetic.
    function automatic int model_env();
        longint sum = 0;
        for (int k = 0; k < N; k++) begin
            longint s = longint'(wl[k]) + longint'(wr[k]);
            longint m = (s < 0) ? -((-s + 1) / 2) : s / 2;
            sum += (m < 0) ? -m : m;
        end
        return int'(sum / N);
    endfunction

    task automatic run_window(input bit gaps);
        int  got = 0;
        int  it = 0;
        bit  v;
        int  env;
        bit  ln;
        bit  fl;
        while (got < N && it < 64) begin
            @(negedge clk);
            it++;
            chk("ready_accum", 32'(sample_ready), 32'd1);
            v = !gaps || ($urandom_range(0, 3) != 0);
            sample_valid = v;
            sample_left  = wl[got][DW-1:0];
            sample_right = wr[got][DW-1:0];
            if (v) got++;
        end
        chk("accept_count", 32'(got), 32'(N));
        @(negedge clk);
        chk("ready_eval", 32'(sample_ready), 32'd0);
        chk("lv_early", 32'(level_valid), 32'd0);
        chk("flap_early", 32'(flap), 32'd0);
        env = model_env();
        ln  = m_loud ? (env >= OFF) : (env >= ON);
        fl  = !m_loud && ln && m_cd == 0;
        m_cd   = fl ? CW : (m_cd > 0 ? m_cd - 1 : 0);
        m_loud = ln;
        if (env > m_peak) m_peak = env;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("envelope", 32'(envelope), 32'(env));
        chk("lv_strobe", 32'(level_valid), 32'd1);
        chk("loud", 32'(loud), 32'(ln));
        chk("flap", 32'(flap), 32'(fl));
        chk("ready_back", 32'(sample_ready), 32'd1);
`ifdef VOICE_FLAP_PEAK_EN
        chk("peak", 32'(peak), 32'(m_peak));
`endif
        @(negedge clk);
        chk("lv_pulse", 32'(level_valid), 32'd0);
        chk("flap_pulse", 32'(flap), 32'd0);
    endtask

    task automatic const_window(input int l, input int r);
        for (int k = 0; k < N; k++) begin
            wl[k] = l;
            wr[k] = r;
        end
        run_window(1'b0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_envelope", 32'(envelope), 32'd0);
        chk("rst_lv", 32'(level_valid), 32'd0);
        chk("rst_loud", 32'(loud), 32'd0);
        chk("rst_flap", 32'(flap), 32'd0);
        chk("rst_ready", 32'(sample_ready), 32'd1);
    endtask

    initial begin
        int a;
        reset_n      = 1'b1;
        sample_valid = 1'b0;
        sample_left  = '0;
        sample_right = '0;
`ifdef VOICE_FLAP_PEAK_EN
        peak_clr = 1'b0;
`endif
        m_loud = 1'b0;
        m_cd   = 0;
        m_peak = 0;
        #3 reset_n = 1'b0;
        #1 chk_reset_outputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_reset_outputs();

        // basic flap, then hysteresis band walk
        const_window(2000, 2000);
        const_window(700, 700);
        const_window(500, 500);
        const_window(499, 499);
        const_window(1000, 1000);

        // drain cooldown, then the suppressed-rise sequence
        repeat (3) const_window(0, 0);
        const_window(2000, 2000);
        const_window(0, 0);
        const_window(2000, 2000);
        const_window(0, 0);
        const_window(0, 0);
        const_window(2000, 2000);

        // full-scale extremes
        const_window(-8388608, -8388608);
        const_window(8388607, -8388608);

        // randomized windows with valid gaps
        repeat (24) begin
            case ($urandom_range(0, 3))
                0: a = 600;
                1: a = 1200;
                2: a = 2400;
                default: a = 0;
            endcase
            for (int k = 0; k < N; k++) begin
                if (a == 0) begin
                    wl[k] = int'($urandom) >>> 8;
                    wr[k] = int'($urandom) >>> 8;
                end else begin
                    wl[k] = int'($urandom_range(0, 2 * a)) - a;
                    wr[k] = int'($urandom_range(0, 2 * a)) - a;
                end
            end
            run_window(1'b1);
        end

        // reset in the middle of a window discards the partial sum
        const_window(2000, 2000);
        chk("loud_before_rst", 32'(loud), 32'd1);
        repeat (2) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_left  = 24'd2000;
            sample_right = 24'd2000;
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        sample_valid = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        m_loud = 1'b0;
        m_cd   = 0;
        m_peak = 0;
        const_window(0, 0);

`ifdef VOICE_FLAP_PEAK_EN
        const_window(2000, 2000);
        const_window(700, 700);
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        m_peak = 0;
        chk("peak_clr", 32'(peak), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
